// File: rtl/test_status_pkg.sv
// Shared definitions for the test-status MMIO responder: verdict encoding,
// register offsets inside the 16-byte window, and the completion signatures
// that firmware writes to the SIGNATURE register.
package test_status_pkg;

  // Verdict state. The encoding is software-visible through the STATE register.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  // Word offsets (dbus_addr[3:2]) inside the window.
  localparam logic [1:0] OFF_CYCLE   = 2'd0;
  localparam logic [1:0] OFF_STATE   = 2'd1;
  localparam logic [1:0] OFF_SCRATCH = 2'd2;
  localparam logic [1:0] OFF_SIG     = 2'd3;

  // Completion signatures. Firmware headers carry the same values.
  localparam logic [31:0] DEFAULT_PASS_CODE = 32'hFFFF_1234;
  localparam logic [31:0] DEFAULT_FAIL_CODE = 32'h1234_FFFF;

  // Merge a write into an existing word: each set byte enable takes the
  // corresponding byte of the new data, the other bytes keep the old value.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/test_status_mmio_sat_counter.sv
// Saturating up-counter: counts while enabled and sticks at all-ones instead
// of wrapping, so a long run never reports a small, misleading cycle count.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  // Count up while enabled; hold once the maximum value is reached.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (en && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/test_status_mmio.sv
// Test-status responder on the core data bus. Firmware writes a completion
// signature to the SIGNATURE register; a PASS or FAIL code latches a sticky
// verdict. A timeout verdict is raised if the run lasts too long. The block
// also exposes a free-running cycle counter and a scratch register.
//
// Bus handshake: a request is a single-cycle dbus_req pulse and is always
// accepted in that cycle (no wait states). Writes commit at the request edge
// and produce no response. A read returns dbus_rdata with dbus_rvalid high for
// exactly one cycle, one cycle after the request; outside that pulse
// dbus_rvalid is low and dbus_rdata keeps its last value. Requests outside the
// 16-byte window are ignored.
module test_status_mmio
  import test_status_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0FF0,
  parameter logic [31:0] PASS_CODE      = DEFAULT_PASS_CODE,
  parameter logic [31:0] FAIL_CODE      = DEFAULT_FAIL_CODE,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dbus_req,
  input  logic        dbus_we,
  input  logic [31:0] dbus_addr,
  input  logic [3:0]  dbus_be,
  input  logic [31:0] dbus_wdata,
  output logic [31:0] dbus_rdata,
  output logic        dbus_rvalid,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] scratch_q;
  logic [31:0] sig_q;
  logic [31:0] sig_next;
  logic [31:0] scratch_next;
  logic [31:0] rd_mux;
  logic        hit;
  logic [1:0]  off;
  logic        rd_hit;
  logic        sig_we;
  logic        scratch_we;
  logic        timeout_hit;
  logic        count_en;

  // Window decode: the low four address bits select within the window and the
  // byte-within-word bits are ignored.
  assign hit        = dbus_req && (dbus_addr[31:4] == BASE_ADDR[31:4]);
  assign off        = dbus_addr[3:2];
  assign rd_hit     = hit && !dbus_we;
  assign sig_we     = hit && dbus_we && (off == OFF_SIG);
  assign scratch_we = hit && dbus_we && (off == OFF_SCRATCH);

  // Post-write register values; the verdict compare looks at the merged word
  // so a signature assembled from several partial writes is recognised.
  assign sig_next     = sig_we     ? be_merge(sig_q, dbus_wdata, dbus_be)     : sig_q;
  assign scratch_next = scratch_we ? be_merge(scratch_q, dbus_wdata, dbus_be) : scratch_q;

  // The counter equals TIMEOUT_CYCLES-1 in the last allowed RUN cycle, so the
  // transition edge moves it to exactly TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) &&
                       (cycle_count == (TIMEOUT_CYCLES - 32'd1));

  // The cycle counter runs only while no verdict has been reached.
  assign count_en = (state_q == ST_RUN);

  sat_counter #(
    .WIDTH(32)
  ) u_cycle_counter (
    .clk  (clk),
    .rstn (rstn),
    .en   (count_en),
    .count(cycle_count)
  );

  // Writable registers: byte-enable merge into SCRATCH and SIGNATURE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scratch_q <= '0;
      sig_q     <= '0;
    end else begin
      scratch_q <= scratch_next;
      sig_q     <= sig_next;
    end
  end

  // Verdict state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Verdict next-state: a terminal signature write wins over a coincident
  // timeout, and every verdict is sticky until reset.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (sig_we && (sig_next == PASS_CODE)) begin
        state_d = ST_PASS;
      end else if (sig_we && (sig_next == FAIL_CODE)) begin
        state_d = ST_FAIL;
      end else if (timeout_hit) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    done    = 1'b0;
    pass    = 1'b0;
    fail    = 1'b0;
    timeout = 1'b0;
    done    = (state_q != ST_RUN);
    pass    = (state_q == ST_PASS);
    fail    = (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
    timeout = (state_q == ST_TIMEOUT);
  end

  // Read data select by word offset.
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CYCLE:   rd_mux = cycle_count;
      OFF_STATE:   rd_mux = {30'b0, state_q};
      OFF_SCRATCH: rd_mux = scratch_q;
      OFF_SIG:     rd_mux = sig_q;
      default:     rd_mux = '0;
    endcase
  end

  // Registered read response: one-cycle rvalid pulse, data held between reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbus_rdata  <= '0;
      dbus_rvalid <= 1'b0;
    end else begin
      dbus_rvalid <= rd_hit;
      if (rd_hit) begin
        dbus_rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_test_status_mmio.sv
// Bench for test_status_mmio: directed bus sequences with hand-computed
// expected values. Read responses are checked by a monitor against a queue of
// expected data and arrival cycles; status outputs are checked directly.
module tb_test_status_mmio;
  import test_status_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_rvalid;
  logic        done, pass, fail, timeout;
  logic [31:0] cycle_count;

  // Second instance with the timeout disabled, driven by the same bus.
  logic [31:0] z_rdata;
  logic        z_rvalid, z_done, z_pass, z_fail, z_timeout;
  logic [31:0] z_cycle_count;

  logic [31:0] exp_q[$];
  int unsigned exp_t_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  test_status_mmio #(.TIMEOUT_CYCLES(32'd20)) dut (
    .clk(clk), .rstn(rstn), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_rvalid(dbus_rvalid), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .cycle_count(cycle_count)
  );

  test_status_mmio #(.TIMEOUT_CYCLES(32'd0)) dut_z (
    .clk(clk), .rstn(rstn), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_rdata(z_rdata), .dbus_rvalid(z_rvalid), .done(z_done),
    .pass(z_pass), .fail(z_fail), .timeout(z_timeout), .cycle_count(z_cycle_count)
  );

  // Clock and cycle stamp.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks: called at a negedge, hold the request across one posedge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    dbus_req = 1'b1; dbus_we = 1'b1; dbus_addr = a; dbus_be = b; dbus_wdata = d;
    @(negedge clk);
    dbus_req = 1'b0; dbus_we = 1'b0; dbus_be = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input bit expect_resp);
    if (expect_resp) begin
      exp_q.push_back(exp);
      exp_t_q.push_back(cyc + 1);
    end
    dbus_req = 1'b1; dbus_we = 1'b0; dbus_addr = a; dbus_be = 4'h0;
    @(negedge clk);
    dbus_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_pass", {31'b0, pass}, 32'd0);
    check("rst_fail", {31'b0, fail}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    check("rst_rvalid", {31'b0, dbus_rvalid}, 32'd0);
    check("rst_rdata", dbus_rdata, 32'd0);
    check("rst_cycle", cycle_count, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Scoreboard monitor: every read response must match the oldest expected
  // entry, in data and in arrival cycle.
  always @(negedge clk) begin
    if (rstn && dbus_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rvalid=1 data %h expected no response (t=%0t)",
                 dbus_rdata, $time);
      end else begin
        check("rd_data", dbus_rdata, exp_q.pop_front());
        check("rd_latency", cyc, exp_t_q.pop_front());
      end
    end
  end

  initial begin
    rstn = 1'b0; dbus_req = 1'b0; dbus_we = 1'b0;
    dbus_addr = '0; dbus_be = '0; dbus_wdata = '0;

    // Reset state, idle count, then PASS verdict and frozen counter.
    do_reset();
    idle(10);
    bus_read(32'h0000_0FF0, 32'd10, 1'b1);
    bus_read(32'h0000_0FF4, 32'd0, 1'b1);
    check("idle_done", {31'b0, done}, 32'd0);
    bus_write(32'h0000_0FFC, 4'hF, 32'hFFFF_1234);
    check("pass_pass", {31'b0, pass}, 32'd1);
    check("pass_done", {31'b0, done}, 32'd1);
    check("pass_fail", {31'b0, fail}, 32'd0);
    bus_read(32'h0000_0FF0, 32'd13, 1'b1);
    idle(5);
    bus_read(32'h0000_0FF0, 32'd13, 1'b1);
    bus_read(32'h0000_0FF4, 32'd1, 1'b1);

    // FAIL built from two partial writes; later PASS write cannot override.
    check("pre_rst_done", {31'b0, done}, 32'd1);
    do_reset();
    idle(2);
    bus_write(32'h0000_0FFC, 4'h3, 32'h1234_FFFF);
    check("half_fail", {31'b0, fail}, 32'd0);
    check("half_done", {31'b0, done}, 32'd0);
    bus_write(32'h0000_0FFC, 4'hC, 32'h1234_FFFF);
    check("fail_fail", {31'b0, fail}, 32'd1);
    check("fail_timeout", {31'b0, timeout}, 32'd0);
    check("fail_pass", {31'b0, pass}, 32'd0);
    bus_write(32'h0000_0FFC, 4'hF, 32'hFFFF_1234);
    check("sticky_fail", {31'b0, fail}, 32'd1);
    check("sticky_pass", {31'b0, pass}, 32'd0);
    bus_read(32'h0000_0FF4, 32'd2, 1'b1);
    bus_read(32'h0000_0FFF, 32'hFFFF_1234, 1'b1);
    bus_read(32'h0000_0FF0, 32'd4, 1'b1);

    // Timeout after 20 idle cycles; the disabled-timeout instance keeps running.
    do_reset();
    idle(19);
    check("pre_to_timeout", {31'b0, timeout}, 32'd0);
    check("pre_to_done", {31'b0, done}, 32'd0);
    idle(1);
    check("to_timeout", {31'b0, timeout}, 32'd1);
    check("to_fail", {31'b0, fail}, 32'd1);
    check("to_done", {31'b0, done}, 32'd1);
    check("to_pass", {31'b0, pass}, 32'd0);
    check("z_timeout", {31'b0, z_timeout}, 32'd0);
    check("z_done", {31'b0, z_done}, 32'd0);
    check("z_cycle", z_cycle_count, 32'd20);
    bus_read(32'h0000_0FF4, 32'd3, 1'b1);
    bus_read(32'h0000_0FF0, 32'd20, 1'b1);

    // PASS written in the last allowed cycle beats the timeout.
    do_reset();
    idle(19);
    bus_write(32'h0000_0FFC, 4'hF, 32'hFFFF_1234);
    check("race_pass", {31'b0, pass}, 32'd1);
    check("race_timeout", {31'b0, timeout}, 32'd0);
    check("race_fail", {31'b0, fail}, 32'd0);
    bus_read(32'h0000_0FF0, 32'd20, 1'b1);

    // Scratch, byte lanes, read-only write drop, and out-of-window accesses.
    do_reset();
    idle(2);
    bus_write(32'h0000_0FF8, 4'hF, 32'hA5A5_5A5A);
    bus_read(32'h0000_0FF0, 32'd3, 1'b1);
    bus_write(32'h0000_0FF0, 4'hF, 32'hDEAD_BEEF);
    bus_read(32'h0000_0FF0, 32'd5, 1'b1);
    bus_read(32'h0000_0FF8, 32'hA5A5_5A5A, 1'b1);
    bus_write(32'h0000_0FF8, 4'b0100, 32'h0033_0000);
    bus_write(32'h0000_0FF8, 4'b0000, 32'hFFFF_FFFF);
    bus_read(32'h0000_0FF8, 32'hA533_5A5A, 1'b1);
    bus_read(32'h0000_1008, 32'd0, 1'b0);
    check("miss_rvalid", {31'b0, dbus_rvalid}, 32'd0);
    check("miss_rdata_hold", dbus_rdata, 32'hA533_5A5A);
    bus_write(32'h0000_100C, 4'hF, 32'hFFFF_1234);
    bus_read(32'h0000_0FF4, 32'd0, 1'b1);
    check("miss_done", {31'b0, done}, 32'd0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
